// File: rtl/mem_access_unit_if.sv
// Purpose: bundles the pipeline request/response handshake and the data-memory
//          bus of mem_access_unit.
// Signals:
//   req_*      pipeline request: valid/ready, we, size, signed, addr, wdata
//   rsp_*      completion pulse with extended load data and error flag
//   MemRe_o/MemWr_o/Adr_o/data_o   word-wide memory access issued by the unit
//   data_i     memory read data returned to the unit
// Modports: slave = the unit itself, master = pipeline + memory environment.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_signed_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              MemRe_o;
    logic              MemWr_o;
    logic [ADDR_W-1:0] Adr_o;
    logic [31:0]       data_o;
    logic [31:0]       data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        input  data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output MemRe_o, MemWr_o, Adr_o, data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        output data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  MemRe_o, MemWr_o, Adr_o, data_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage initiator for a byte-addressed little-endian data memory.
//          Turns byte/half/word loads and stores into word-aligned MemRe/MemWr
//          accesses; sub-word stores use read-modify-write.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    mem_access_unit_if.slave (request/response handshake + memory bus)
// Parameters: RD_WAIT (read-enable cycles before data_i is sampled, >=1), ADDR_W.
// Build option: MISALIGN_TRAP_EN -- when defined, misaligned/illegal requests
//   complete in one cycle with rsp_err_o=1 and no memory access; when undefined
//   they are force-aligned and size 11 behaves as word.
module mem_access_unit #(
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_access_unit_if.slave bus
);
    localparam int unsigned CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [1:0]  SZ_B  = 2'b00;
    localparam logic [1:0]  SZ_H  = 2'b01;
    localparam logic [1:0]  SZ_W  = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] rd_cnt;
    logic             we_q;
    logic             signed_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic [31:0]      wdata_q;

    logic [1:0]       req_size_c;
    logic [1:0]       req_lane_c;

    // Effective size and force-aligned byte lane of the incoming request
    always_comb begin
        req_size_c = (bus.req_size_i == 2'b11) ? SZ_W : bus.req_size_i;
        case (req_size_c)
            SZ_B:    req_lane_c = bus.req_addr_i[1:0];
            SZ_H:    req_lane_c = {bus.req_addr_i[1], 1'b0};
            default: req_lane_c = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic req_err_c;

    // Illegal size or misaligned half/word
    always_comb begin
        case (bus.req_size_i)
            SZ_B:    req_err_c = 1'b0;
            SZ_H:    req_err_c = bus.req_addr_i[0];
            SZ_W:    req_err_c = |bus.req_addr_i[1:0];
            default: req_err_c = 1'b1;
        endcase
    end
`endif

    // Select the addressed lane of a read word and extend it
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] lane, input logic sgn);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (size)
            SZ_B:    load_ext = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    load_ext = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    // Replace the addressed lane of a read word with the store data
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [31:0] wd);
        logic [31:0] m;
        m = w;
        case (size)
            SZ_B:    m[{lane, 3'b000} +: 8]        = wd[7:0];
            SZ_H:    m[{lane[1], 4'b0000} +: 16]   = wd[15:0];
            default: m                             = wd;
        endcase
        return m;
    endfunction

    // Access sequencer with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            rd_cnt          <= '0;
            we_q            <= 1'b0;
            signed_q        <= 1'b0;
            size_q          <= 2'b00;
            lane_q          <= 2'b00;
            wdata_q         <= 32'h0;
            bus.req_ready_o <= 1'b1;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= 32'h0;
            bus.rsp_err_o   <= 1'b0;
            bus.MemRe_o     <= 1'b0;
            bus.MemWr_o     <= 1'b0;
            bus.Adr_o       <= '0;
            bus.data_o      <= 32'h0;
        end else begin
            // response fields are a one-cycle pulse
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= 32'h0;
            bus.rsp_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        we_q            <= bus.req_we_i;
                        signed_q        <= bus.req_signed_i;
                        size_q          <= req_size_c;
                        lane_q          <= req_lane_c;
                        wdata_q         <= bus.req_wdata_i;
                        rd_cnt          <= '0;
                        bus.req_ready_o <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        if (req_err_c) begin
                            state           <= RESP;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_err_o   <= 1'b1;
                        end else
`endif
                        begin
                            bus.Adr_o <= {bus.req_addr_i[ADDR_W-1:2], 2'b00};
                            if (bus.req_we_i && req_size_c == SZ_W) begin
                                state       <= WRITE;
                                bus.MemWr_o <= 1'b1;
                                bus.data_o  <= bus.req_wdata_i;
                            end else begin
                                state       <= READ;
                                bus.MemRe_o <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    if (rd_cnt == CNT_W'(RD_WAIT - 1)) begin
                        bus.MemRe_o <= 1'b0;
                        if (we_q) begin
                            state       <= WRITE;
                            bus.MemWr_o <= 1'b1;
                            bus.data_o  <= store_merge(bus.data_i, size_q, lane_q, wdata_q);
                        end else begin
                            state           <= RESP;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_rdata_o <= load_ext(bus.data_i, size_q, lane_q, signed_q);
                        end
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    bus.MemWr_o     <= 1'b0;
                    state           <= RESP;
                    bus.rsp_valid_o <= 1'b1;
                end
                RESP: begin
                    state           <= IDLE;
                    bus.req_ready_o <= 1'b1;
                end
                default: begin
                    state           <= IDLE;
                    bus.req_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: scoreboard bench for mem_access_unit (RD_WAIT=3) with a 16-word memory model.
module tb_mem_access_unit;
    localparam int unsigned RD_WAIT = 3;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          mem_cycles = 0;
    bit          both_seen = 1'b0;
    logic [31:0] mem [0:15];
    exp_t        sb[$];

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.RD_WAIT(RD_WAIT), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: combinational read, write on the clock edge
    assign bus.data_i = mem[bus.Adr_o[5:2]];
    always @(posedge clk) begin
        if (bus.MemWr_o) mem[bus.Adr_o[5:2]] <= bus.data_o;
        if (bus.MemRe_o || bus.MemWr_o) mem_cycles <= mem_cycles + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pop and compare whenever a response is presented
    initial begin
        forever begin
            @(negedge clk);
            if (bus.MemRe_o && bus.MemWr_o) both_seen = 1'b1;
            if (!rst && bus.rsp_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h with empty scoreboard", bus.rsp_rdata_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                    check("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    // drive a request and leave valid high after it is accepted
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input bit push, output int acc);
        int n;
        exp_t e;
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_size_i   = size;
        bus.req_signed_i = sgn;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wd;
        n = 0;
        while (!bus.req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 100 cycles");
        end else if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = lat;
            e.acc   = acc;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int a0, a1, m0, n;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h44332211;
        mem[2] = 32'hDEADBEEF;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_size_i   = 2'b00;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.req_ready_o), 32'h1);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        check("rst_memre", 32'(bus.MemRe_o), 32'h0);
        check("rst_memwr", 32'(bus.MemWr_o), 32'h0);
        check("rst_adr", bus.Adr_o, 32'h0);
        check("rst_data_o", bus.data_o, 32'h0);

        // word load, signed half, unsigned byte
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, RD_WAIT + 1, 1'b1, a0);
        idle();
        drain();
        check("load_adr", bus.Adr_o, 32'h8);
        issue(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'hFFFFDEAD, 1'b0, RD_WAIT + 1, 1'b1, a0);
        issue(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h000000BE, 1'b0, RD_WAIT + 1, 1'b1, a0);
        idle();
        drain();

        // word store then word load held valid back-to-back
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h80112233, 32'h0, 1'b0, 2, 1'b1, a0);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h80112233, 1'b0, RD_WAIT + 1, 1'b1, a1);
        idle();
        drain();
        check("b2b_accept_gap", 32'(a1 - a0), 32'd3);
        check("word_store_mem", mem[2], 32'h80112233);

        // signed / unsigned byte load of 0x80
        issue(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'hFFFFFF80, 1'b0, RD_WAIT + 1, 1'b1, a0);
        issue(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'h00000080, 1'b0, RD_WAIT + 1, 1'b1, a0);
        idle();
        drain();

        // sub-word read-modify-write stores
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h123456AA, 32'h0, 1'b0, RD_WAIT + 2, 1'b1, a0);
        idle();
        drain();
        check("byte_store_mem", mem[1], 32'h4433AA11);
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h9999BEEF, 32'h0, 1'b0, RD_WAIT + 2, 1'b1, a0);
        idle();
        drain();
        check("half_store_mem", mem[1], 32'hBEEFAA11);

        // aligned half load, then misaligned/illegal accesses
        issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h0000BEEF, 1'b0, RD_WAIT + 1, 1'b1, a0);
        idle();
        drain();
        m0 = mem_cycles;
        issue(1'b0, 2'b01, 1'b0, 32'h7, 32'h0, TRAP ? 32'h0 : 32'h0000BEEF, TRAP,
              TRAP ? 1 : RD_WAIT + 1, 1'b1, a0);
        idle();
        drain();
        check("misalign_half_mem_cycles", 32'(mem_cycles - m0), TRAP ? 32'd0 : 32'(RD_WAIT));
        issue(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, TRAP ? 32'h0 : 32'hBEEFAA11, TRAP,
              TRAP ? 1 : RD_WAIT + 1, 1'b1, a0);
        issue(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, TRAP ? 32'h0 : 32'hBEEFAA11, TRAP,
              TRAP ? 1 : RD_WAIT + 1, 1'b1, a0);
        m0 = mem_cycles;
        issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h11111111, 32'h0, TRAP,
              TRAP ? 1 : 2, 1'b1, a0);
        idle();
        drain();
        check("misalign_store_mem", mem[1], TRAP ? 32'hBEEFAA11 : 32'h11111111);
        mem[1] = 32'hBEEFAA11;

        // reset during the WRITE cycle of a byte store
        issue(1'b1, 2'b00, 1'b0, 32'h4, 32'h00000055, 32'h0, 1'b0, 0, 1'b0, a0);
        idle();
        n = 0;
        while (!bus.MemWr_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rmw_reached_write", 32'(bus.MemWr_o), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_memwr", 32'(bus.MemWr_o), 32'h0);
        check("rst_mid_ready", 32'(bus.req_ready_o), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_mem_kept", mem[1], 32'hBEEFAA11);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hBEEFAA11, 1'b0, RD_WAIT + 1, 1'b1, a0);
        idle();
        drain();

        check("never_both_enables", 32'(both_seen), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
